// File: rtl/load_store_unit.sv
// uPOWER load/store initiator: EA calc, size decode, one handshaked mem txn.
// Optional LSU_ALIGN_CHECK_EN rejects misaligned EAs before any mem request.
module load_store_unit #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [5:0]        opcode,
  input  logic [ADDR_W-1:0] base,
  input  logic [15:0]       disp,
  input  logic [DATA_W-1:0] store_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] load_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              sext_q, sext_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] ld_q, ld_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic              op_lbz, op_lhz, op_lha, op_lwz, op_ld;
  logic              op_stb, op_sth, op_stw, op_std;
  logic              legal, dec_we, dec_sext, ds_form;
  logic [1:0]        dec_size;
  logic [15:0]       disp_v;
  logic [ADDR_W-1:0] ea;
  logic              misal;
  logic [DATA_W-1:0] st_mask;
  logic [DATA_W-1:0] ld_ext;

  assign op_lbz = opcode == 6'd34;
  assign op_lhz = opcode == 6'd40;
  assign op_lha = opcode == 6'd42;
  assign op_lwz = opcode == 6'd32;
  assign op_ld  = opcode == 6'd58;
  assign op_stb = opcode == 6'd38;
  assign op_sth = opcode == 6'd44;
  assign op_stw = opcode == 6'd36;
  assign op_std = opcode == 6'd62;

  always_comb begin
    legal    = 1'b1;
    dec_we   = 1'b0;
    dec_size = 2'd0;
    dec_sext = 1'b0;
    ds_form  = 1'b0;
    unique case (1'b1)
      op_lbz: dec_size = 2'd0;
      op_lhz: dec_size = 2'd1;
      op_lha: begin
        dec_size = 2'd1;
        dec_sext = 1'b1;
      end
      op_lwz: dec_size = 2'd2;
      op_ld: begin
        dec_size = 2'd3;
        ds_form  = 1'b1;
      end
      op_stb: dec_we = 1'b1;
      op_sth: begin
        dec_we   = 1'b1;
        dec_size = 2'd1;
      end
      op_stw: begin
        dec_we   = 1'b1;
        dec_size = 2'd2;
      end
      op_std: begin
        dec_we   = 1'b1;
        dec_size = 2'd3;
        ds_form  = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  // DS-form encodes opcode extension in disp[1:0]; it is not offset.
  assign disp_v = ds_form ? {disp[15:2], 2'b00} : disp;
  assign ea     = base + {{(ADDR_W-16){disp_v[15]}}, disp_v};

`ifdef LSU_ALIGN_CHECK_EN
  always_comb begin
    misal = 1'b0;
    unique case (dec_size)
      2'd1:    misal = ea[0];
      2'd2:    misal = |ea[1:0];
      2'd3:    misal = |ea[2:0];
      default: misal = 1'b0;
    endcase
  end
`else
  assign misal = 1'b0;
`endif

  always_comb begin
    st_mask = '0;
    unique case (dec_size)
      2'd0:    st_mask = DATA_W'(store_data[7:0]);
      2'd1:    st_mask = DATA_W'(store_data[15:0]);
      2'd2:    st_mask = DATA_W'(store_data[31:0]);
      default: st_mask = store_data;
    endcase
  end

  always_comb begin
    ld_ext = '0;
    unique case (size_q)
      2'd0: ld_ext = DATA_W'(mem_rdata[7:0]);
      2'd1: begin
        if (sext_q)
          ld_ext = {{(DATA_W-16){mem_rdata[15]}}, mem_rdata[15:0]};
        else
          ld_ext = DATA_W'(mem_rdata[15:0]);
      end
      2'd2:    ld_ext = DATA_W'(mem_rdata[31:0]);
      default: ld_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    we_d    = we_q;
    size_d  = size_q;
    sext_d  = sext_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ld_d    = ld_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (!legal || misal) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = S_REQ;
            we_d    = dec_we;
            size_d  = dec_size;
            sext_d  = dec_sext;
            addr_d  = ea;
            wdata_d = dec_we ? st_mask : '0;
            cnt_d   = '0;
          end
        end
      end
      S_REQ: begin
        if (mem_ready) begin
          state_d = S_DONE;
          if (!we_q)
            ld_d = ld_ext;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      sext_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ld_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ld_q    <= ld_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy      = state_q != S_IDLE;
  assign done      = state_q == S_DONE;
  assign err       = err_q;
  assign mem_req   = state_q == S_REQ;
  assign mem_we    = we_q;
  assign mem_size  = size_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign load_data = ld_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface. Turns a uPOWER load/store request from the execute stage into one handshaked memory transaction.
- Computes the effective address, selects the access size from the opcode and drives the memory request. Returns zero- or sign-extended load data with a one-cycle completion pulse.
- Sits between the execute stage and the data-memory responder.

Parameters:
- ADDR_W, 64, address width of the base, the effective address and mem_addr.
- DATA_W, 64, data width of the register and memory data paths.
- TIMEOUT, 16, maximum cycles spent in REQ waiting for mem_ready before aborting with err.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request strobe from execute; sampled only in IDLE.
- opcode  input  6  primary opcode: 34 lbz, 40 lhz, 42 lha, 32 lwz, 58 ld, 38 stb, 44 sth, 36 stw, 62 std.
- base  input  ADDR_W  RA operand value.
- disp  input  16  D/DS displacement field.
- store_data  input  DATA_W  RS operand value.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- err  output  1  valid with done: illegal opcode, timeout or misalignment.
- load_data  output  DATA_W  extended load result; holds its value until the next successful load.
- mem_req  output  1  memory request valid.
- mem_we  output  1  1 = store, 0 = load.
- mem_size  output  2  0 byte, 1 half, 2 word, 3 double.
- mem_addr  output  ADDR_W  effective address.
- mem_wdata  output  DATA_W  store data masked to size, upper bits zero.
- mem_ready  input  1  responder acceptance/completion.
- mem_rdata  input  DATA_W  read data, valid while mem_ready is high on a load.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE. busy, done, err, mem_req, mem_we, mem_size = 0. mem_addr, mem_wdata, load_data, timeout counter = 0.
- Effective address: EA = base + sign_extend(disp), modulo 2^ADDR_W. For opcodes 58/62 (DS-form), disp[1:0] is forced to 00 before extension.
- State IDLE: start=1 latches opcode, EA and store_data.
  - Legal opcode → REQ.
  - Illegal opcode → DONE with err=1; no memory access.
- State REQ: mem_req=1; mem_addr, mem_we, mem_size and mem_wdata are held stable.
  - mem_ready=1 is sampled on a clock edge; on that edge the unit captures mem_rdata (loads only) → DONE.
  - The counter increments each REQ cycle without mem_ready. When it reaches TIMEOUT → DONE with err=1, load_data unchanged, mem_req drops.
- State DONE: done=1 for exactly one cycle, mem_req=0 → IDLE. Counter clears.
- Load extension:
  - lbz/lhz/lwz zero-extend mem_rdata[7:0] / [15:0] / [31:0].
  - lha sign-extends mem_rdata[15:0].
  - ld passes all 64 bits.
- Store masking: mem_wdata = store_data masked to the byte/half/word/double width; the rest is zero.
- Latency: start on edge N, mem_req high after edge N, mem_ready high at edge N+1, done high after edge N+1, IDLE after edge N+2. Minimum 2 cycles start-to-done; each wait cycle adds 1.
- start while busy=1: ignored, no queueing. A start in the same cycle as done is also ignored, since the state is DONE, not IDLE.
- mem_ready outside REQ: ignored.
- Reset mid-transaction: mem_req and busy drop immediately (asynchronously). No done pulse is produced and the partial transaction is abandoned.
- err is low whenever done is low.

Optional Feature:
- Macro: LSU_ALIGN_CHECK_EN.
- Defined: an EA not aligned to the access size (half: EA[0]!=0; word: EA[1:0]!=0; double: EA[2:0]!=0) goes IDLE → DONE with err=1. No mem_req is issued.
- Undefined: no alignment check; misaligned EAs are issued unchanged. Responder behaviour is outside this block.

Test Plan:
- Reset, then start with stb (38), base=0x10, disp=0xFFFF, store_data=0xDEAD_BEEF_1234_56E9, mem_ready=1 → mem_addr=0x0F, mem_we=1, mem_size=0, mem_wdata=0xE9; done one cycle later, err=0.
- lha (42), base=0x20, disp=4, mem_rdata=0x0000_0000_0000_8001, ready after 3 wait cycles → load_data=0xFFFF_FFFF_FFFF_8001, done 5 cycles after start.
- ld (58) with disp=0x0013 → mem_addr=base+0x10, mem_size=3; mem_rdata passes through unchanged.
- mem_ready held 0 with TIMEOUT=16 → mem_req drops after 16 REQ cycles; done=1, err=1; load_data keeps its prior value.
- Illegal opcode 6'd0, and a second start while busy → first gives done+err with no mem_req; second is ignored, one done total.
- Reset asserted during REQ → mem_req and busy go 0 without a clock edge; no done. With LSU_ALIGN_CHECK_EN defined, lwz at EA=0x102 → err, no mem_req.
